// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES forward cipher: FSM state
// encoding, block width, round-count derivation and the byte-level round
// transforms (SubBytes, ShiftRows, MixColumns, AddRoundKey).
// State byte i sits at bits [8*i +: 8]; byte i is row i%4, column i/4.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUNDS = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } aes_state_e;

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, with 0 -> 0) followed by the
  // affine transform; avoids a 256-entry table per byte lane.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:BLOCK_W-1] sub_bytes(input logic [0:BLOCK_W-1] s);
    logic [0:BLOCK_W-1] o;
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [0:BLOCK_W-1] shift_rows(input logic [0:BLOCK_W-1] s);
    logic [0:BLOCK_W-1] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:BLOCK_W-1] mix_columns(input logic [0:BLOCK_W-1] s);
    logic [0:BLOCK_W-1] o;
    logic [7:0] a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [0:BLOCK_W-1] add_round_key(input logic [0:BLOCK_W-1] s,
                                                       input logic [0:BLOCK_W-1] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round. The last flag bypasses
// MixColumns for the final round.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] state,
  input  logic [0:BLOCK_W-1] round_key,
  input  logic               last,
  output logic [0:BLOCK_W-1] next_state
);

  logic [0:BLOCK_W-1] sb;
  logic [0:BLOCK_W-1] sr;
  logic [0:BLOCK_W-1] mc;

  // SubBytes -> ShiftRows -> (MixColumns unless last) -> AddRoundKey.
  always_comb begin
    sb         = sub_bytes(state);
    sr         = shift_rows(sb);
    mc         = last ? sr : mix_columns(sr);
    next_state = add_round_key(mc, round_key);
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative FIPS-197 forward cipher, one round per clock.
// Optional macro AES_CIPHER_ABORT_EN adds an abort input that cancels a
// block in ROUNDS/FINAL without a done pulse.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = nr_of(Nk)
) (
  input  logic                         clks,
  input  logic                         reset,
  input  logic                         start,
`ifdef AES_CIPHER_ABORT_EN
  input  logic                         abort,
`endif
  input  logic [0:BLOCK_W-1]           plainText,
  input  logic [0:BLOCK_W*(Nr+1)-1]    keys,
  output logic                         busy,
  output logic                         done,
  output logic [0:BLOCK_W-1]           encryptedText
);

  localparam logic [4:0] LAST_MID = 5'(Nr - 1);

  aes_state_e         state_q, state_d;
  logic [4:0]         round_q, round_d;
  logic [0:BLOCK_W-1] st_q, st_d;
  logic [0:BLOCK_W-1] ct_q, ct_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_w;
  logic [0:BLOCK_W-1] rkey;
  logic [0:BLOCK_W-1] round_out;

`ifdef AES_CIPHER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Round keys exposed as a 32-entry table so the 5-bit round counter
  // indexes it directly; entries beyond Nr are tied to zero.
  logic [0:BLOCK_W-1] rkeys [0:31];
  for (genvar g = 0; g < 32; g++) begin : g_rk
    if (g <= Nr) begin : g_used
      assign rkeys[g] = keys[BLOCK_W*g +: BLOCK_W];
    end else begin : g_unused
      assign rkeys[g] = '0;
    end
  end

  assign rkey = rkeys[round_q];

  aes_enc_round u_round (
    .state      (st_q),
    .round_key  (rkey),
    .last       (state_q == FINAL),
    .next_state (round_out)
  );

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      round_q <= '0;
      st_q    <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and register-input logic; done defaults low so it is a
  // single-cycle pulse issued from DONE.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    ct_d    = ct_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort_w) begin
          st_d    = plainText ^ rkeys[0];
          round_d = 5'd1;
          busy_d  = 1'b1;
          state_d = ROUNDS;
        end
      end
      ROUNDS: begin
        if (abort_w) begin
          round_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          st_d    = round_out;
          round_d = round_q + 5'd1;
          if (round_q == LAST_MID) state_d = FINAL;
        end
      end
      FINAL: begin
        if (abort_w) begin
          round_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          st_d    = round_out;
          ct_d    = round_out;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        round_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign encryptedText = ct_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: three instances (Nk = 4, 6, 8)
// checked every cycle against a cycle-count model with a byte-array AES.
module tb_aes_cipher_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_v [3];
  logic         abort_v [3];
  logic [0:127] pt_v    [3];
  logic [0:1919] ks_v   [3];
  logic         busy_v  [3];
  logic         done_v  [3];
  logic [0:127] ct_v    [3];

  int checks = 0;
  int errors = 0;
  int nr_tab [3] = '{10, 12, 14};

  aes_cipher_iter #(.Nk(4)) u4 (
    .clks(clk), .reset(rst), .start(start_v[0]),
`ifdef AES_CIPHER_ABORT_EN
    .abort(abort_v[0]),
`endif
    .plainText(pt_v[0]), .keys(ks_v[0][0:1407]),
    .busy(busy_v[0]), .done(done_v[0]), .encryptedText(ct_v[0]));

  aes_cipher_iter #(.Nk(6)) u6 (
    .clks(clk), .reset(rst), .start(start_v[1]),
`ifdef AES_CIPHER_ABORT_EN
    .abort(abort_v[1]),
`endif
    .plainText(pt_v[1]), .keys(ks_v[1][0:1663]),
    .busy(busy_v[1]), .done(done_v[1]), .encryptedText(ct_v[1]));

  aes_cipher_iter #(.Nk(8)) u8 (
    .clks(clk), .reset(rst), .start(start_v[2]),
`ifdef AES_CIPHER_ABORT_EN
    .abort(abort_v[2]),
`endif
    .plainText(pt_v[2]), .keys(ks_v[2][0:1919]),
    .busy(busy_v[2]), .done(done_v[2]), .encryptedText(ct_v[2]));

  // ---------------- reference AES (byte arrays) ----------------
  logic [7:0] sbox [0:255];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:1919] ks;
    int nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[32*j +: 32];
    for (int j = nk; j < nw; j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t = subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end else if (nk > 6 && j % nk == 4) begin
        t = subw(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    ks = '0;
    for (int j = 0; j < nw; j++) ks[32*j +: 32] = w[j];
    return ks;
  endfunction

  function automatic logic [0:127] model_enc(input logic [0:127] pt, input logic [0:1919] ks,
                                             input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] rk;
    logic [0:127] o;
    rk = ks[0:127];
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[8*i +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row + 4*((c+row)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      rk = ks[128*r +: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle model ----------------
  // Counts edges since the accepting edge: result at Nr, done at Nr+1,
  // idle again (able to accept) from the edge after that.
  bit           m_active [3] = '{0, 0, 0};
  int           m_k      [3] = '{0, 0, 0};
  logic         m_busy   [3] = '{0, 0, 0};
  logic         m_done   [3] = '{0, 0, 0};
  logic [0:127] m_ct     [3] = '{'0, '0, '0};
  logic [0:127] m_exp    [3] = '{'0, '0, '0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_active[i] = 0; m_k[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_ct[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_done[i] = 1'b0;
        if (m_active[i]) begin
          m_k[i]++;
          if (abort_v[i] && m_k[i] <= nr_tab[i]) begin
            m_active[i] = 0;
            m_busy[i]   = 1'b0;
          end else if (m_k[i] == nr_tab[i]) begin
            m_ct[i] = m_exp[i];
          end else if (m_k[i] == nr_tab[i] + 1) begin
            m_done[i]   = 1'b1;
            m_busy[i]   = 1'b0;
            m_active[i] = 0;
          end
        end else if (start_v[i] && !abort_v[i]) begin
          m_active[i] = 1;
          m_k[i]      = 0;
          m_busy[i]   = 1'b1;
          m_exp[i]    = model_enc(pt_v[i], ks_v[i], nr_tab[i]);
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy%0d", i), {127'd0, busy_v[i]}, {127'd0, m_busy[i]});
      chk($sformatf("done%0d", i), {127'd0, done_v[i]}, {127'd0, m_done[i]});
      chk($sformatf("ct%0d", i), ct_v[i], m_ct[i]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_block(input int i, input logic [0:127] p, input logic [0:127] exp_ct,
                           input string name);
    int n;
    @(negedge clk);
    pt_v[i]    = p;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    n = 0;
    while (!done_v[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[i]) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      chk({name, "_lat"}, 128'(n), 128'(nr_tab[i] + 1));
      chk({name, "_ct"}, ct_v[i], exp_ct);
    end
  endtask

  task automatic count_done(input int i, input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done_v[i]) pulses++;
    end
  endtask

  localparam logic [0:255] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first_k;
    int second_k;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0; pt_v[i] = '0;
    end
    build_sbox();
    ks_v[0] = expand_key(KEY_B, 4);
    ks_v[1] = expand_key(KEY_C2, 6);
    ks_v[2] = expand_key(KEY_C3, 8);
    #1 rst = 1'b0;

    // Pin the reference model to the published vectors.
    chk("model_B",  model_enc(PT_B, ks_v[0], 10), CT_B);
    chk("model_C1", model_enc(PT_C, expand_key(KEY_C1, 4), 10), CT_C1);
    chk("model_C2", model_enc(PT_C, ks_v[1], 12), CT_C2);
    chk("model_C3", model_enc(PT_C, ks_v[2], 14), CT_C3);

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy%0d", i), {127'd0, busy_v[i]}, 128'd0);
      chk($sformatf("rst_done%0d", i), {127'd0, done_v[i]}, 128'd0);
      chk($sformatf("rst_ct%0d", i), ct_v[i], 128'd0);
    end
    rst = 1'b1;

    run_block(0, PT_B, CT_B, "nk4_B");
    ks_v[0] = expand_key(KEY_C1, 4);
    run_block(0, PT_C, CT_C1, "nk4_C1");
    run_block(1, PT_C, CT_C2, "nk6_C2");
    run_block(2, PT_C, CT_C3, "nk8_C3");

    // start held high for 30 cycles: pulses after 11 and 23 edges only.
    @(negedge clk);
    pt_v[0] = PT_B;
    ks_v[0] = expand_key(KEY_B, 4);
    start_v[0] = 1'b1;
    pulses = 0; first_k = -1; second_k = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_v[0]) begin
        pulses++;
        if (first_k < 0) first_k = k; else if (second_k < 0) second_k = k;
      end
    end
    start_v[0] = 1'b0;
    chk("held_pulses", 128'(pulses), 128'd2);
    chk("held_first", 128'(first_k), 128'd11);
    chk("held_second", 128'(second_k), 128'd23);
    chk("held_ct", ct_v[0], CT_B);
    repeat (15) @(negedge clk);

    // Reset at round 5 abandons the block.
    ks_v[0] = expand_key(KEY_C1, 4);
    @(negedge clk);
    pt_v[0] = PT_C;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {127'd0, busy_v[0]}, 128'd0);
    chk("midrst_done", {127'd0, done_v[0]}, 128'd0);
    chk("midrst_ct", ct_v[0], 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_done(0, 15, pulses);
    chk("midrst_nodone", 128'(pulses), 128'd0);
    run_block(0, PT_C, CT_C1, "post_rst");

`ifdef AES_CIPHER_ABORT_EN
    // Abort with round counter at 3.
    @(negedge clk);
    pt_v[0] = PT_B;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_busy", {127'd0, busy_v[0]}, 128'd0);
    chk("abort_ct", ct_v[0], CT_C1);
    count_done(0, 15, pulses);
    chk("abort_nodone", 128'(pulses), 128'd0);
    chk("abort_ct_hold", ct_v[0], CT_C1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words (legal values 4, 6 and 8).
REQ-002 SHALL have parameter Nr, default Nk+6, round count.
REQ-003 SHALL have port clks  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to encrypt plainText.
REQ-006 SHALL have port plainText  input  [0:127]  plaintext block; bit 0 is the MSB of byte 0.
REQ-007 SHALL have port keys  input  [0:128*(Nr+1)-1]  expanded key schedule; round key r at bits [128*r : 128*r+127].
REQ-008 SHALL have port busy  output  1  high while an encryption is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port encryptedText  output  [0:127]  ciphertext, registered.

Function
REQ-011 SHALL implement the FIPS-197 forward cipher, one round per clock cycle.
REQ-012 SHALL use FSM states IDLE, ROUNDS, FINAL and DONE.
REQ-013 IDLE SHALL, when start=1, register plainText XOR round key 0, set round=1, set busy=1 and go to ROUNDS.
REQ-014 ROUNDS SHALL, each cycle, apply SubBytes, ShiftRows, MixColumns and AddRoundKey(round) to the state, then increment round; after round Nr-1 it SHALL go to FINAL.
REQ-015 FINAL SHALL apply SubBytes, ShiftRows and AddRoundKey(Nr) (no MixColumns), load encryptedText and go to DONE.
REQ-016 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-017 Latency SHALL be Nr+1 cycles from the start sample edge to done high: 11, 13 and 15 cycles for Nk = 4, 6 and 8.
REQ-018 start SHALL be ignored in every state except IDLE, including start held high through DONE.
REQ-019 The same-cycle return path SHALL be DONE then IDLE; start is sampled in IDLE on the following edge, giving a back-to-back throughput of one block per Nr+2 cycles.
REQ-020 The round counter SHALL be 5 bits wide and SHALL never exceed Nr.
REQ-021 keys SHALL be sampled every cycle and not captured; the caller holds keys stable while busy=1, and a key change mid-operation yields an undefined ciphertext but SHALL NOT corrupt the FSM.
REQ-022 encryptedText SHALL hold its value until the next FINAL state.

Reset
REQ-023 reset=0 SHALL, asynchronously, force state=IDLE, round=0, busy=0, done=0, encryptedText=0 and clear the internal state register to zero.
REQ-024 Reset asserted mid-operation SHALL abandon the block with no done pulse; the first start after reset release SHALL be processed normally.

Configuration
REQ-025 The macro AES_CIPHER_ABORT_EN SHALL, when defined, add port abort (input, 1 bit).
REQ-026 With AES_CIPHER_ABORT_EN defined, abort=1 in ROUNDS or FINAL SHALL return the FSM to IDLE on the next edge with busy=0, no done pulse and encryptedText unchanged.
REQ-027 abort SHALL take precedence over start when both are asserted.
REQ-028 Without AES_CIPHER_ABORT_EN, the abort port SHALL be absent and behaviour SHALL be as in REQ-011 to REQ-022.

Structure
REQ-029 Package aes_pkg SHALL hold the FSM state encoding, the block width constant (128), and the Nr derivation function Nk+6.
REQ-030 One combinational sub-module aes_enc_round (inputs: state, round key, last flag; output: next state) SHALL be instantiated once and built from the existing SubBytes, ShiftRows, MixColumns and AddRoundKey blocks.
REQ-031 The last flag SHALL bypass MixColumns.

Verification
REQ-032 Nk=4, pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> encryptedText=3925841d02dc09fbdc118597196a0b32, with done exactly 11 cycles after start.
REQ-033 Nk=4, pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Nk=6 and Nk=8 with the FIPS-197 C.2/C.3 vectors -> dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089, with latencies 13 and 15 cycles.
REQ-035 start held high for 30 cycles (Nk=4) -> done pulses at cycles 11 and 23, with no extra pulses and correct outputs.
REQ-036 reset=0 asserted at round 5, then start after release -> no done for the aborted block, all outputs zero during reset, and the next block is correct.
REQ-037 With AES_CIPHER_ABORT_EN defined, abort at round 3 -> busy=0 next cycle, no done, and encryptedText retains the previous result.
